// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: two-master arbiter/sequencer for the shared data-memory bus.
//   Master 0 = core load/store port, master 1 = debug/DMA port.
//   Each transaction runs IDLE -> ACCESS -> RESP. The address is decoded into
//   data RAM / peripheral / stack regions. One-hot selects and a read or write
//   strobe are driven for the single ACCESS cycle. The read data is registered
//   and returned with a one-cycle ack in RESP.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mX_req/we/addr/wdata          master X request and payload (X = 0, 1)
//   mX_ack/rdata/err              master X response, valid for one cycle
//   bus_addr, bus_wdata           latched address / write data (ACCESS only)
//   bus_rd, bus_wr                read / write strobes
//   sel_data/periph/stack         one-hot region selects
//   rdata_data/periph/stack       read data returned by each region
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give master 0 fixed
//   priority. By default, ties are arbitrated round-robin.
module dmem_bus_arbiter #(
  parameter int unsigned    AW          = 32,
  parameter int unsigned    DW          = 32,
  parameter logic [AW-1:0]  DATA_BASE   = AW'(32'h0000_0000),
  parameter logic [AW-1:0]  PERIPH_BASE = AW'(32'h0000_2000),
  parameter logic [AW-1:0]  STACK_BASE  = AW'(32'h0000_3000)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_rd,
  output logic          bus_wr,
  output logic          sel_data,
  output logic          sel_periph,
  output logic          sel_stack,
  input  logic [DW-1:0] rdata_data,
  input  logic [DW-1:0] rdata_periph,
  input  logic [DW-1:0] rdata_stack
);

  localparam logic [AW-1:0] DATA_SIZE   = AW'(32'h2000);
  localparam logic [AW-1:0] PERIPH_SIZE = AW'(32'h1000);
  localparam logic [AW-1:0] STACK_SIZE  = AW'(32'h1000);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_next;

  logic          gnt_q;     // granted master id
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic [2:0]    sel_q;     // {stack, periph, data}
  logic [DW-1:0] rdata_q;

  logic          grant_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          err_d;
  logic [2:0]    sel_d;
  logic [DW-1:0] rdata_d;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic          last_grant;
`endif

  // Arbitration and decode of the winning request (only consumed in IDLE).
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    grant_d = ~m0_req;
`else
    grant_d = (m0_req && m1_req) ? ~last_grant : ~m0_req;
`endif
    we_d    = grant_d ? m1_we    : m0_we;
    addr_d  = grant_d ? m1_addr  : m0_addr;
    wdata_d = grant_d ? m1_wdata : m0_wdata;

    // Offset compare: (addr - base) < size covers both range bounds,
    // because an address below base wraps to a large offset.
    sel_d = '0;
    if (addr_d[1:0] == 2'b00) begin
      if ((addr_d - DATA_BASE) < DATA_SIZE)          sel_d = 3'b001;
      else if ((addr_d - PERIPH_BASE) < PERIPH_SIZE) sel_d = 3'b010;
      else if ((addr_d - STACK_BASE) < STACK_SIZE)   sel_d = 3'b100;
    end
    err_d = (sel_d == 3'b000);
  end

  // Read data captured at the end of ACCESS. It is zero for writes and errors.
  always_comb begin
    rdata_d = '0;
    if (!err_q && !we_q) begin
      unique case (sel_q)
        3'b001:  rdata_d = rdata_data;
        3'b010:  rdata_d = rdata_periph;
        3'b100:  rdata_d = rdata_stack;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus_rd     = 1'b0;
    bus_wr     = 1'b0;
    sel_data   = 1'b0;
    sel_periph = 1'b0;
    sel_stack  = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) state_next = ACCESS;
      end
      ACCESS: begin
        bus_addr   = addr_q;
        bus_wdata  = wdata_q;
        bus_rd     = ~err_q & ~we_q;
        bus_wr     = ~err_q &  we_q;
        sel_data   = sel_q[0];
        sel_periph = sel_q[1];
        sel_stack  = sel_q[2];
        state_next = RESP;
      end
      RESP: begin
        m0_ack     = ~gnt_q;
        m1_ack     =  gnt_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    m0_rdata = m0_ack ? rdata_q : '0;
    m1_rdata = m1_ack ? rdata_q : '0;
    m0_err   = m0_ack & err_q;
    m1_err   = m1_ack & err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      sel_q      <= '0;
      rdata_q    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (state == IDLE && (m0_req || m1_req)) begin
        gnt_q      <= grant_d;
        we_q       <= we_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        err_q      <= err_d;
        sel_q      <= sel_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant <= grant_d;
`endif
      end
      if (state == ACCESS) rdata_q <= rdata_d;
    end
  end

endmodule
